// File: rtl/hash_stage_agent.sv
// Processor-side crossbar endpoint: walks the input array and builds an occurrence hash table.
// Optional collision counter (collision_cnt port) enabled by defining HASH_AGENT_COLLISION_EN.
module hash_stage_agent #(
  parameter int unsigned LENGTH_ARRAY     = 100,
  parameter int unsigned DATA_INDEX_WIDTH = 32,
  parameter int unsigned BIT_ON_TAILS     = 7,
  parameter int unsigned COUNT_WIDTH      = 16,
  parameter int unsigned FIRST_STAGE      = 1,
  localparam int unsigned IW = $clog2(LENGTH_ARRAY),
  localparam int unsigned SW = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        interrupt,
  input  logic                        cont,
  input  logic                        transfered,
  output logic [SW-1:0]               state,
  output logic [IW-1:0]               index,
  output logic                        waiting,
  output logic                        done,
`ifdef HASH_AGENT_COLLISION_EN
  output logic [15:0]                 collision_cnt,
`endif
  output logic                        data_req,
  input  logic                        data_valid,
  input  logic [DATA_INDEX_WIDTH-1:0] data_in,
  output logic [BIT_ON_TAILS-1:0]     hash_addr,
  output logic                        hash_rd_en,
  input  logic [COUNT_WIDTH-1:0]      hash_rd_data,
  output logic                        hash_wr_en,
  output logic [COUNT_WIDTH-1:0]      hash_wr_data
);

  typedef enum logic [SW-1:0] {
    StWait             = 4'd0,
    StWaitForInterrupt = 4'd1,
    StFetch            = 4'd2,
    StWaitDataStream   = 4'd3,
    StFirstTempIndex   = 4'd4,
    StWaitTempIndex    = 4'd5,
    StRdHashOccurr     = 4'd6,
    StCollisionCal     = 4'd7,
    StHashBuild        = 4'd8
  } state_e;

  localparam logic [IW-1:0] LastIdx = IW'(LENGTH_ARRAY - 1);

  state_e                  r_state, w_state_next;
  logic [IW-1:0]           r_index, w_index_next;
  logic                    r_waiting, w_waiting_next;
  logic                    r_done, w_done_next;
  logic [BIT_ON_TAILS-1:0] r_key, w_key_next;
  logic [COUNT_WIDTH-1:0]  r_count, w_count_next;
  logic [COUNT_WIDTH-1:0]  r_wr_data, w_wr_data_next;
  logic                    r_hb_phase, w_hb_phase_next;
  logic                    w_cont_accept;
  logic                    w_run_start;
  logic                    w_unused_data;

  // Only the key bits of the datum matter.
  assign w_unused_data = ^data_in[DATA_INDEX_WIDTH-1:BIT_ON_TAILS];

  // A parked, unfinished agent resumes on cont even if start arrives in the same cycle.
  assign w_cont_accept = (r_state == StWait) && r_waiting && !r_done && cont;
  assign w_run_start   = (r_state == StWait) && start && !w_cont_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StWait;
      r_index    <= '0;
      r_waiting  <= 1'b0;
      r_done     <= 1'b0;
      r_key      <= '0;
      r_count    <= '0;
      r_wr_data  <= '0;
      r_hb_phase <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_index    <= w_index_next;
      r_waiting  <= w_waiting_next;
      r_done     <= w_done_next;
      r_key      <= w_key_next;
      r_count    <= w_count_next;
      r_wr_data  <= w_wr_data_next;
      r_hb_phase <= w_hb_phase_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_index_next    = r_index;
    w_waiting_next  = r_waiting;
    w_done_next     = r_done;
    w_key_next      = r_key;
    w_count_next    = r_count;
    w_wr_data_next  = r_wr_data;
    w_hb_phase_next = r_hb_phase;
    case (r_state)
      StWait: begin
        if (w_cont_accept) begin
          if (r_index == LastIdx) begin
            w_done_next = 1'b1;
          end else begin
            w_waiting_next = 1'b0;
            w_index_next   = r_index + 1'b1;
            w_state_next   = StFetch;
          end
        end else if (w_run_start) begin
          w_done_next    = 1'b0;
          w_waiting_next = 1'b0;
          w_index_next   = '0;
          w_state_next   = (FIRST_STAGE != 0) ? StFetch : StWaitForInterrupt;
        end
      end
      StWaitForInterrupt: begin
        if (transfered) w_state_next = StFetch;
      end
      StFetch: w_state_next = StWaitDataStream;
      StWaitDataStream: begin
        if (data_valid) begin
          w_key_next   = data_in[BIT_ON_TAILS-1:0];
          w_state_next = StFirstTempIndex;
        end
      end
      StFirstTempIndex: w_state_next = StWaitTempIndex;
      StWaitTempIndex:  w_state_next = StRdHashOccurr;
      StRdHashOccurr: begin
        w_count_next = hash_rd_data;
        w_state_next = StCollisionCal;
      end
      StCollisionCal: begin
        w_wr_data_next = (&r_count) ? r_count : r_count + 1'b1;
        w_state_next   = StHashBuild;
      end
      StHashBuild: begin
        if (!r_hb_phase) begin
          w_hb_phase_next = 1'b1;
        end else begin
          w_hb_phase_next = 1'b0;
          if (interrupt) begin
            w_waiting_next = 1'b1;
            w_state_next   = StWait;
          end else if (r_index == LastIdx) begin
            w_done_next    = 1'b1;
            w_waiting_next = 1'b1;
            w_state_next   = StWait;
          end else begin
            w_index_next = r_index + 1'b1;
            w_state_next = StFetch;
          end
        end
      end
      default: w_state_next = StWait;
    endcase
  end

`ifdef HASH_AGENT_COLLISION_EN
  logic [15:0] r_collision;

  always_ff @(posedge clk) begin
    if (rst || w_run_start) begin
      r_collision <= '0;
    end else if ((r_state == StRdHashOccurr) && (hash_rd_data != '0) &&
                 (r_collision != 16'hFFFF)) begin
      r_collision <= r_collision + 16'd1;
    end
  end

  assign collision_cnt = r_collision;
`endif

  // Strobes are gated by rst so nothing reaches the table in the reset cycle.
  assign state        = r_state;
  assign index        = r_index;
  assign waiting      = r_waiting;
  assign done         = r_done;
  assign data_req     = (r_state == StFetch) && !rst;
  assign hash_addr    = r_key;
  assign hash_rd_en   = (r_state == StFirstTempIndex) && !rst;
  assign hash_wr_en   = (r_state == StHashBuild) && !r_hb_phase && !rst;
  assign hash_wr_data = r_wr_data;

endmodule

// File: tb/tb_hash_stage_agent.sv
// Directed bench for hash_stage_agent: vector table plus handshake corner-case sequences.
// Two instances: first stage (main checks) and non-first stage (handover wait).
module tb_hash_stage_agent;

  logic        clk = 1'b0;
  logic        rst, start, start2, interrupt, cont, transfered, data_valid;
  logic [31:0] data_in;
  logic [3:0]  state, state2;
  logic [6:0]  index, index2, hash_addr, hash_addr2;
  logic        waiting, done, data_req, hash_rd_en, hash_wr_en;
  logic        waiting2, done2, data_req2, hash_rd_en2, hash_wr_en2;
  logic [15:0] hash_rd_data, hash_wr_data, hash_wr_data2;
`ifdef HASH_AGENT_COLLISION_EN
  logic [15:0] collision_cnt, collision_cnt2;
`endif

  logic [15:0] mem [128];
  logic        mem_clr, pre_en;
  logic [6:0]  pre_addr;
  logic [15:0] pre_val;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hash_stage_agent #(.FIRST_STAGE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .interrupt(interrupt), .cont(cont),
    .transfered(transfered), .state(state), .index(index), .waiting(waiting), .done(done),
`ifdef HASH_AGENT_COLLISION_EN
    .collision_cnt(collision_cnt),
`endif
    .data_req(data_req), .data_valid(data_valid), .data_in(data_in), .hash_addr(hash_addr),
    .hash_rd_en(hash_rd_en), .hash_rd_data(hash_rd_data), .hash_wr_en(hash_wr_en),
    .hash_wr_data(hash_wr_data)
  );

  hash_stage_agent #(.FIRST_STAGE(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .interrupt(interrupt), .cont(cont),
    .transfered(transfered), .state(state2), .index(index2), .waiting(waiting2), .done(done2),
`ifdef HASH_AGENT_COLLISION_EN
    .collision_cnt(collision_cnt2),
`endif
    .data_req(data_req2), .data_valid(1'b0), .data_in(data_in), .hash_addr(hash_addr2),
    .hash_rd_en(hash_rd_en2), .hash_rd_data(16'h0000), .hash_wr_en(hash_wr_en2),
    .hash_wr_data(hash_wr_data2)
  );

  // Table RAM with 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else begin
      if (pre_en) mem[pre_addr] <= pre_val;
      if (hash_wr_en) mem[hash_addr] <= hash_wr_data;
    end
    if (hash_rd_en) hash_rd_data <= mem[hash_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (hash_wr_en) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!data_req && n < 100) begin tick(); n++; end
    if (!data_req) chk("data_req_timeout", {31'b0, data_req}, 1);
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!hash_wr_en && n < 40) begin tick(); n++; end
    if (!hash_wr_en) chk("hash_wr_en_timeout", {31'b0, hash_wr_en}, 1);
  endtask

  task automatic serve(input logic [31:0] d, input int dly, input logic pe,
                       input logic [15:0] pv);
    wait_req();
    tick();
    repeat (dly) tick();
    data_valid = 1'b1;
    data_in    = d;
    pre_en     = pe;
    pre_addr   = d[6:0];
    pre_val    = pv;
    tick();
    data_valid = 1'b0;
    pre_en     = 1'b0;
  endtask

  // Wait for the write, then raise interrupt during the second HashBuild cycle.
  task automatic park();
    wait_wr();
    tick();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_state"}, state, 0);
    chk({p, "_index"}, index, 0);
    chk({p, "_waiting"}, waiting, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_strobes"}, {data_req, hash_rd_en, hash_wr_en}, 0);
    chk({p, "_hash_addr"}, hash_addr, 0);
    chk({p, "_hash_wr_data"}, hash_wr_data, 0);
`ifdef HASH_AGENT_COLLISION_EN
    chk({p, "_collision_cnt"}, collision_cnt, 0);
`endif
  endtask

  typedef struct {
    logic [31:0] data;
    int          dly;
    logic        pre;
    logic [15:0] pre_val;
    logic [6:0]  addr;
    logic [15:0] wr;
  } vec_t;

  vec_t vt[8];

  initial begin
    int bad, t0, n, wr0;
    vt[0] = '{32'd5,          0, 1'b0, 16'h0000, 7'd5,   16'd1};
    vt[1] = '{32'd133,        1, 1'b0, 16'h0000, 7'd5,   16'd2};
    vt[2] = '{32'd5,          0, 1'b0, 16'h0000, 7'd5,   16'd3};
    vt[3] = '{32'hDEADBEEF,   3, 1'b0, 16'h0000, 7'h6F,  16'd1};
    vt[4] = '{32'h0000_0080,  0, 1'b0, 16'h0000, 7'd0,   16'd1};
    vt[5] = '{32'hFFFF_FF80,  2, 1'b0, 16'h0000, 7'd0,   16'd2};
    vt[6] = '{32'd42,         0, 1'b1, 16'hFFFF, 7'd42,  16'hFFFF};
    vt[7] = '{32'd383,        0, 1'b0, 16'h0000, 7'd127, 16'd1};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; interrupt = 1'b0; cont = 1'b0;
    transfered = 1'b0; data_valid = 1'b0; data_in = '0;
    mem_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    tick(); tick();
    chk_reset("por");
    rst = 1'b0;
    tick();
    mem_clr = 1'b0;

    // Table vectors: keys, data_valid delays, collisions and saturation.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_state", state, 2);
    for (int i = 0; i < 8; i++) begin
      serve(vt[i].data, vt[i].dly, vt[i].pre, vt[i].pre_val);
      wait_wr();
      chk($sformatf("vec%0d_index", i), index, i);
      chk($sformatf("vec%0d_addr", i), hash_addr, vt[i].addr);
      chk($sformatf("vec%0d_wr_data", i), hash_wr_data, vt[i].wr);
    end
`ifdef HASH_AGENT_COLLISION_EN
    chk("vec_collisions", collision_cnt, 4);
`endif

    // Abort with rst while waiting for data at index 17.
    for (int i = 8; i < 17; i++) serve(200 + i, 0, 1'b0, 16'h0);
    wait_req();
    chk("abort_index", index, 17);
    tick();
    chk("abort_wds_state", state, 3);
    rst = 1'b1; mem_clr = 1'b1;
    tick();
    chk_reset("abort");
    rst = 1'b0; mem_clr = 1'b0;
    tick();

    // Full run, data 0..99.
    wr0 = wr_cnt;
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    chk("run1_start_state", state, 2);
    chk("run1_start_index", index, 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      serve(k, 0, 1'b0, 16'h0);
      wait_wr();
      if (hash_addr !== k[6:0] || hash_wr_data !== 16'd1) bad++;
    end
    chk("run1_bad_writes", bad, 0);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("run1_done", done, 1);
    chk("run1_cycles", cyc - t0, 800);
    chk("run1_wr_count", wr_cnt - wr0, 100);
    chk("run1_parked", {waiting, state, index}, {1'b1, 4'd0, 7'd99});
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ((i < 100) ? 16'd1 : 16'd0)) bad++;
    chk("run1_table", bad, 0);
    cont = 1'b1; tick(); cont = 1'b0;
    chk("cont_ignored_done", {done, state, index, data_req}, {1'b1, 4'd0, 7'd99, 1'b0});

    // Interrupt at index 40, resume with cont.
    start = 1'b1; tick(); start = 1'b0;
    chk("run2_start", {done, waiting, state, index}, {1'b0, 1'b0, 4'd2, 7'd0});
    for (int k = 0; k < 40; k++) begin serve(k + 300, 0, 1'b0, 16'h0); wait_wr(); end
    serve(340, 0, 1'b0, 16'h0);
    park();
    chk("int40_parked", {waiting, done, state, index}, {1'b1, 1'b0, 4'd0, 7'd40});
    bad = 0;
    repeat (10) begin tick(); if (state !== 4'd0 || waiting !== 1'b1) bad++; end
    chk("int40_hold", bad, 0);
    cont = 1'b1; tick(); cont = 1'b0;
    chk("int40_resume", {waiting, state, index}, {1'b0, 4'd2, 7'd41});

    // Simultaneous cont and start while parked: cont wins.
    serve(341, 0, 1'b0, 16'h0);
    park();
    chk("int41_parked", {waiting, state, index}, {1'b1, 4'd0, 7'd41});
    cont = 1'b1; start = 1'b1; tick(); cont = 1'b0; start = 1'b0;
    chk("cont_beats_start", {waiting, state, index}, {1'b0, 4'd2, 7'd42});

    // Interrupt at the last index, then cont completes the run without wrapping.
    for (int k = 42; k < 99; k++) begin serve(k + 300, 0, 1'b0, 16'h0); wait_wr(); end
    serve(399, 0, 1'b0, 16'h0);
    park();
    chk("int99_parked", {waiting, done, state, index}, {1'b1, 1'b0, 4'd0, 7'd99});
    cont = 1'b1; tick(); cont = 1'b0;
    chk("int99_cont_done", {waiting, done, state, index}, {1'b1, 1'b1, 4'd0, 7'd99});

    // Non-first stage holds for the upstream handover.
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("stage2_wfi", state2, 1);
    bad = 0;
    repeat (5) begin tick(); if (state2 !== 4'd1 || data_req2 !== 1'b0) bad++; end
    chk("stage2_hold", bad, 0);
    transfered = 1'b1; tick(); transfered = 1'b0;
    chk("stage2_fetch", {state2, index2, data_req2}, {4'd2, 7'd0, 1'b1});
    chk("stage2_idle_outs", {waiting2, done2, hash_rd_en2, hash_wr_en2, hash_addr2,
                             hash_wr_data2}, 0);
`ifdef HASH_AGENT_COLLISION_EN
    chk("stage2_collisions", collision_cnt2, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
